// File: rtl/hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller_pkg
//  Description : Shared types and constants for the pipeline hazard
//                controller: decoded-instruction record, bypass selects,
//                hazard FSM state encoding and the default M-unit latency.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_controller_pkg;

    localparam int MUL_LATENCY_DEFAULT = 4;

    // Decoded instruction record carried through DEC/EXE/MEM.
    typedef struct packed {
        logic       valid;
        logic       reg_write_enable;
        logic [4:0] dst_reg;
        logic [4:0] src_reg_1;
        logic [4:0] src_reg_2;
        logic       is_l;
        logic       is_s;
        logic       is_b;
        logic       is_m;
    } inst_decoded_t;

    // Per-source forwarding select from one producer stage.
    typedef struct packed {
        logic dep_src1;
        logic dep_src2;
    } bypass_t;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } hazard_state_e;

endpackage : hazard_controller_pkg
`default_nettype wire

// File: rtl/hazard_controller_perf_counter.sv
`default_nettype none
// ============================================================================
//  Module      : perf_counter
//  Description : Enabled free-running event counter, wraps modulo 2^WIDTH.
//  Ports       : clk, rst (async, active-high), en (count this cycle),
//                count (current value)
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule : perf_counter
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller
//  Description : Hazard control for the 5-stage RV32IM pipeline. Produces
//                EXE/MEM bypass selects, load-to-use stall, multi-cycle
//                M-extension EXE occupancy, taken-branch flush of FET/DEC,
//                global freeze on data-memory busy, and stall/flush counters.
//  Ports       : clk, rst (async, active-high)
//                inst_dec_in/inst_exe_in/inst_mem_in - stage instructions
//                branch_taken, mem_busy              - qualified internally
//                exe_bypass, mem_bypass              - forwarding selects
//                load_to_use_hazard, stall_*, bubble_*, flush_fd, mul_busy
//                stall_cycles, flush_count           - perf counters
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  inst_decoded_t        inst_dec_in,
    input  inst_decoded_t        inst_exe_in,
    input  inst_decoded_t        inst_mem_in,
    input  logic                 branch_taken,
    input  logic                 mem_busy,
    output bypass_t              exe_bypass,
    output bypass_t              mem_bypass,
    output logic                 load_to_use_hazard,
    output logic                 stall_fetch,
    output logic                 stall_decode,
    output logic                 stall_exe,
    output logic                 stall_mem,
    output logic                 bubble_exe,
    output logic                 bubble_mem,
    output logic                 bubble_wb,
    output logic                 flush_fd,
    output logic                 mul_busy,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    // mcnt counts the stalled MUL_WAIT cycles still owed after entry.
    localparam logic [3:0] MCNT_INIT = 4'(MUL_LATENCY - 2);

    hazard_state_e state;
    logic [3:0]    mcnt;

    bypass_t exe_dep;
    bypass_t mem_dep;
    logic    frozen;
    logic    mul_entry;
    logic    mul_hold;
    logic    mul_stall;
    logic    flush;
    logic    load_use;
    logic    unused_ok;

    // Source/destination match, producer must write a non-zero register.
    always_comb begin
        exe_dep.dep_src1 = inst_exe_in.valid & inst_exe_in.reg_write_enable & inst_dec_in.valid
                         & (inst_exe_in.dst_reg != 5'd0)
                         & (inst_exe_in.dst_reg == inst_dec_in.src_reg_1);
        exe_dep.dep_src2 = inst_exe_in.valid & inst_exe_in.reg_write_enable & inst_dec_in.valid
                         & (inst_exe_in.dst_reg != 5'd0)
                         & (inst_exe_in.dst_reg == inst_dec_in.src_reg_2);
        mem_dep.dep_src1 = inst_mem_in.valid & inst_mem_in.reg_write_enable & inst_dec_in.valid
                         & (inst_mem_in.dst_reg != 5'd0)
                         & (inst_mem_in.dst_reg == inst_dec_in.src_reg_1);
        mem_dep.dep_src2 = inst_mem_in.valid & inst_mem_in.reg_write_enable & inst_dec_in.valid
                         & (inst_mem_in.dst_reg != 5'd0)
                         & (inst_mem_in.dst_reg == inst_dec_in.src_reg_2);
    end

    // Priority chain: freeze > MUL (entry or wait) > flush > load-to-use.
    // Everything is gated by !rst so reset silences the control outputs.
    always_comb begin
        frozen    = ~rst & inst_mem_in.valid & (inst_mem_in.is_l | inst_mem_in.is_s) & mem_busy;
        mul_entry = ~rst & ~frozen & (state == RUN) & inst_exe_in.valid & inst_exe_in.is_m;
        mul_hold  = ~rst & ~frozen & (state == MUL_WAIT) & (mcnt != 4'd0);
        mul_stall = mul_entry | mul_hold;
        flush     = ~rst & ~frozen & ~mul_stall & (state == RUN)
                  & inst_exe_in.valid & inst_exe_in.is_b & branch_taken;
        load_use  = ~rst & ~frozen & ~mul_stall & ~flush & inst_exe_in.is_l
                  & (exe_dep.dep_src1 | exe_dep.dep_src2);
    end

    always_comb begin
        exe_bypass         = flush ? bypass_t'(2'b00) : exe_dep;
        mem_bypass         = flush ? bypass_t'(2'b00) : mem_dep;
        load_to_use_hazard = load_use;
        stall_fetch        = frozen | mul_stall | load_use;
        stall_decode       = frozen | mul_stall | load_use;
        stall_exe          = frozen | mul_stall;
        stall_mem          = frozen;
        bubble_exe         = load_use;
        bubble_mem         = mul_stall;
        bubble_wb          = frozen;
        flush_fd           = flush;
    end

    // Freeze holds state and mcnt; reaching mcnt==0 in MUL_WAIT is the
    // unstalled release cycle where the M instruction leaves EXE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            mcnt     <= 4'd0;
            mul_busy <= 1'b0;
        end else if (!frozen) begin
            case (state)
                RUN: begin
                    if (mul_entry) begin
                        state    <= MUL_WAIT;
                        mcnt     <= MCNT_INIT;
                        mul_busy <= 1'b1;
                    end
                end
                MUL_WAIT: begin
                    if (mcnt != 4'd0) begin
                        mcnt <= mcnt - 4'd1;
                    end else begin
                        state    <= RUN;
                        mul_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    mcnt     <= 4'd0;
                    mul_busy <= 1'b0;
                end
            endcase
        end
    end

    perf_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_fetch),
        .count (stall_cycles)
    );

    perf_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush_fd),
        .count (flush_count)
    );

    // Several decoded fields are irrelevant in some stages.
    assign unused_ok = ^{inst_dec_in, inst_exe_in, inst_mem_in};

endmodule : hazard_controller
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_controller
//  Description : Scoreboard bench for hazard_controller (MUL_LATENCY = 4).
//                Directed vectors push hand-computed expected outputs into a
//                queue; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    // Flag vector order: l2u sf sd se sm be bm bw fl busy
    localparam logic [9:0] F_NONE  = 10'b0000000000;
    localparam logic [9:0] F_L2U   = 10'b1110010000;
    localparam logic [9:0] F_MENT  = 10'b0111001000;
    localparam logic [9:0] F_MWAIT = 10'b0111001001;
    localparam logic [9:0] F_MREL  = 10'b0000000001;
    localparam logic [9:0] F_FRZ   = 10'b0111100100;
    localparam logic [9:0] F_FRZM  = 10'b0111100101;
    localparam logic [9:0] F_FLUSH = 10'b0000000010;

    typedef struct packed {
        logic [1:0]  eb;
        logic [1:0]  mbp;
        logic [9:0]  fl;
        logic [31:0] sc;
        logic [31:0] fc;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    inst_decoded_t dec_i = '0;
    inst_decoded_t exe_i = '0;
    inst_decoded_t mem_i = '0;
    logic          bt = 1'b0;
    logic          mbz = 1'b0;

    bypass_t     exe_bypass, mem_bypass;
    logic        l2u, sf, sd, se, sm, be, bm, bw, ffd, busy;
    logic [31:0] stall_cycles, flush_count;

    obs_t  q_exp[$];
    string q_name[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    hazard_controller #(.MUL_LATENCY(4), .CNT_W(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .inst_dec_in        (dec_i),
        .inst_exe_in        (exe_i),
        .inst_mem_in        (mem_i),
        .branch_taken       (bt),
        .mem_busy           (mbz),
        .exe_bypass         (exe_bypass),
        .mem_bypass         (mem_bypass),
        .load_to_use_hazard (l2u),
        .stall_fetch        (sf),
        .stall_decode       (sd),
        .stall_exe          (se),
        .stall_mem          (sm),
        .bubble_exe         (be),
        .bubble_mem         (bm),
        .bubble_wb          (bw),
        .flush_fd           (ffd),
        .mul_busy           (busy),
        .stall_cycles       (stall_cycles),
        .flush_count        (flush_count)
    );

    function automatic inst_decoded_t ins(logic v, logic we, int dst, int s1, int s2,
                                          logic l, logic s, logic b, logic m);
        inst_decoded_t r;
        r.valid            = v;
        r.reg_write_enable = we;
        r.dst_reg          = 5'(dst);
        r.src_reg_1        = 5'(s1);
        r.src_reg_2        = 5'(s2);
        r.is_l             = l;
        r.is_s             = s;
        r.is_b             = b;
        r.is_m             = m;
        return r;
    endfunction

    function automatic obs_t ob(logic [1:0] eb, logic [1:0] mbp, logic [9:0] fl, int sc, int fc);
        obs_t o;
        o.eb  = eb;
        o.mbp = mbp;
        o.fl  = fl;
        o.sc  = 32'(sc);
        o.fc  = 32'(fc);
        return o;
    endfunction

    // One stimulus cycle: apply inputs just after the edge, queue expectation.
    task automatic cyc(input string nm, input logic r, input inst_decoded_t d,
                       input inst_decoded_t x, input inst_decoded_t m,
                       input logic b, input logic busy_in, input obs_t e);
        @(posedge clk);
        #1;
        rst   = r;
        dec_i = d;
        exe_i = x;
        mem_i = m;
        bt    = b;
        mbz   = busy_in;
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    // Monitor: pops one expectation per cycle and compares all outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                obs_t  e;
                obs_t  a;
                string nm;
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                a  = ob(exe_bypass, mem_bypass,
                        {l2u, sf, sd, se, sm, be, bm, bw, ffd, busy},
                        int'(stall_cycles), int'(flush_count));
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got eb=%b mb=%b flags=%b sc=%0d fc=%0d, want eb=%b mb=%b flags=%b sc=%0d fc=%0d",
                             nm, a.eb, a.mbp, a.fl, a.sc, a.fc, e.eb, e.mbp, e.fl, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        inst_decoded_t nop, addi5, addi0, add655, add600, add651, lw7, add871, mul9;
        inst_decoded_t beq, ldbr, lw3, sw;
        nop    = '0;
        addi5  = ins(1, 1, 5, 1, 0, 0, 0, 0, 0);
        addi0  = ins(1, 1, 0, 1, 0, 0, 0, 0, 0);
        add655 = ins(1, 1, 6, 5, 5, 0, 0, 0, 0);
        add600 = ins(1, 1, 6, 0, 0, 0, 0, 0, 0);
        add651 = ins(1, 1, 6, 5, 1, 0, 0, 0, 0);
        lw7    = ins(1, 1, 7, 2, 0, 1, 0, 0, 0);
        add871 = ins(1, 1, 8, 7, 1, 0, 0, 0, 0);
        mul9   = ins(1, 1, 9, 3, 4, 0, 0, 0, 1);
        beq    = ins(1, 0, 0, 1, 2, 0, 0, 1, 0);
        ldbr   = ins(1, 1, 7, 2, 0, 1, 0, 1, 0);
        lw3    = ins(1, 1, 3, 2, 0, 1, 0, 0, 0);
        sw     = ins(1, 0, 0, 2, 3, 0, 1, 0, 0);

        #2 rst = 1'b1;
        cyc("reset_state",   1, nop, nop, nop, 0, 0, ob(0, 0, F_NONE, 0, 0));
        cyc("reset_mul_in",  1, nop, mul9, nop, 0, 0, ob(0, 0, F_NONE, 0, 0));
        cyc("idle",          0, nop, nop, nop, 0, 0, ob(0, 0, F_NONE, 0, 0));
        // Bypass
        cyc("bypass_exe",    0, add655, addi5, nop, 0, 0, ob(2'b11, 0, F_NONE, 0, 0));
        cyc("bypass_x0",     0, add600, addi0, nop, 0, 0, ob(0, 0, F_NONE, 0, 0));
        cyc("bypass_both",   0, add651, addi5, addi5, 0, 0, ob(2'b10, 2'b10, F_NONE, 0, 0));
        // Load-to-use
        cyc("l2u_detect",    0, add871, lw7, nop, 0, 0, ob(2'b10, 0, F_L2U, 0, 0));
        cyc("l2u_mem_byp",   0, add871, nop, lw7, 0, 0, ob(0, 2'b10, F_NONE, 1, 0));
        cyc("idle_after_lu", 0, nop, nop, nop, 0, 0, ob(0, 0, F_NONE, 1, 0));
        // MUL latency 4
        cyc("mul_t0",        0, nop, mul9, nop, 0, 0, ob(0, 0, F_MENT, 1, 0));
        cyc("mul_t1",        0, nop, mul9, nop, 0, 0, ob(0, 0, F_MWAIT, 2, 0));
        cyc("mul_t2",        0, nop, mul9, nop, 0, 0, ob(0, 0, F_MWAIT, 3, 0));
        cyc("mul_t3_rel",    0, nop, mul9, nop, 0, 0, ob(0, 0, F_MREL, 4, 0));
        cyc("mul_done",      0, nop, nop, nop, 0, 0, ob(0, 0, F_NONE, 4, 0));
        // Branch flush
        cyc("flush_byp0",    0, add871, beq, lw7, 1, 0, ob(0, 0, F_FLUSH, 4, 0));
        cyc("flush_over_lu", 0, add871, ldbr, nop, 1, 0, ob(0, 0, F_FLUSH, 4, 1));
        cyc("br_not_taken",  0, nop, beq, nop, 0, 0, ob(0, 0, F_NONE, 4, 2));
        cyc("br_invalid",    0, nop, ins(0, 0, 0, 0, 0, 0, 0, 1, 0), nop, 1, 0, ob(0, 0, F_NONE, 4, 2));
        // Freeze during MUL_WAIT with mcnt == 1
        cyc("fz_mul_t0",     0, nop, mul9, nop, 0, 0, ob(0, 0, F_MENT, 4, 2));
        cyc("fz_mul_t1",     0, nop, mul9, nop, 0, 0, ob(0, 0, F_MWAIT, 5, 2));
        cyc("freeze_1",      0, nop, mul9, lw3, 0, 1, ob(0, 0, F_FRZM, 6, 2));
        cyc("freeze_2",      0, nop, mul9, lw3, 0, 1, ob(0, 0, F_FRZM, 7, 2));
        cyc("freeze_3",      0, nop, mul9, lw3, 0, 1, ob(0, 0, F_FRZM, 8, 2));
        cyc("fz_resume",     0, nop, mul9, nop, 0, 0, ob(0, 0, F_MWAIT, 9, 2));
        cyc("fz_release",    0, nop, mul9, nop, 0, 0, ob(0, 0, F_MREL, 10, 2));
        cyc("fz_idle",       0, nop, nop, nop, 0, 0, ob(0, 0, F_NONE, 10, 2));
        // Branch held across a freeze flushes exactly once
        cyc("br_frozen",     0, nop, beq, sw, 1, 1, ob(0, 0, F_FRZ, 10, 2));
        cyc("br_after_fz",   0, nop, beq, nop, 1, 0, ob(0, 0, F_FLUSH, 11, 2));
        cyc("br_fz_idle",    0, nop, nop, nop, 0, 0, ob(0, 0, F_NONE, 11, 3));
        // Freeze suppresses load-to-use but not bypass
        cyc("fz_over_lu",    0, add871, lw7, lw3, 0, 1, ob(2'b10, 0, F_FRZ, 11, 3));
        // Reset in the middle of MUL_WAIT
        cyc("rs_mul_t0",     0, nop, mul9, nop, 0, 0, ob(0, 0, F_MENT, 12, 3));
        cyc("rs_mul_t1",     0, nop, mul9, nop, 0, 0, ob(0, 0, F_MWAIT, 13, 3));
        cyc("rs_async",      1, nop, mul9, nop, 0, 0, ob(0, 0, F_NONE, 0, 0));
        cyc("rs_idle",       0, nop, nop, nop, 0, 0, ob(0, 0, F_NONE, 0, 0));
        // Back-to-back M instructions, no idle cycle between
        cyc("b2b_a0",        0, nop, mul9, nop, 0, 0, ob(0, 0, F_MENT, 0, 0));
        cyc("b2b_a1",        0, nop, mul9, nop, 0, 0, ob(0, 0, F_MWAIT, 1, 0));
        cyc("b2b_a2",        0, nop, mul9, nop, 0, 0, ob(0, 0, F_MWAIT, 2, 0));
        cyc("b2b_a_rel",     0, nop, mul9, nop, 0, 0, ob(0, 0, F_MREL, 3, 0));
        cyc("b2b_b0",        0, nop, mul9, nop, 0, 0, ob(0, 0, F_MENT, 3, 0));
        cyc("b2b_b1",        0, nop, mul9, nop, 0, 0, ob(0, 0, F_MWAIT, 4, 0));
        cyc("b2b_b2",        0, nop, mul9, nop, 0, 0, ob(0, 0, F_MWAIT, 5, 0));
        cyc("b2b_b_rel",     0, nop, mul9, nop, 0, 0, ob(0, 0, F_MREL, 6, 0));
        cyc("final_idle",    0, nop, nop, nop, 0, 0, ob(0, 0, F_NONE, 6, 0));

        @(negedge clk);
        #1;
        if (q_exp.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_hazard_controller
`default_nettype wire

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard controller for the 5-stage RV32IM core. From the decoded instruction in DEC and the instructions in EXE and MEM, it computes the EXE/MEM bypass selects and the load-to-use stall consumed by `decode_stage`. It also sequences multi-cycle M-extension occupancy of EXE, the taken-branch flush of FET/DEC, and the global freeze on data-memory busy. It exposes stall/flush performance counters.

## Interface
Parameters:
- `MUL_LATENCY`, default 4: total cycles an `is_m` instruction occupies EXE. Legal range is 2..16.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  reset; asynchronous, active-high
- `inst_dec_in`  in  `inst_decoded_t`  instruction currently in DEC
- `inst_exe_in`  in  `inst_decoded_t`  instruction currently in EXE
- `inst_mem_in`  in  `inst_decoded_t`  instruction currently in MEM
- `branch_taken`  in  1  EXE branch resolved taken; qualified internally by `inst_exe_in.valid & inst_exe_in.is_b`
- `mem_busy`  in  1  data memory not ready; qualified by `inst_mem_in.valid & (is_l | is_s)`
- `exe_bypass`  out  `bypass_t`  DEC source matches EXE destination
- `mem_bypass`  out  `bypass_t`  DEC source matches MEM destination
- `load_to_use_hazard`  out  1  hold FET/DEC and inject a bubble into EXE
- `stall_fetch`, `stall_decode`, `stall_exe`, `stall_mem`  out  1 each  hold the stage register
- `bubble_exe`, `bubble_mem`, `bubble_wb`  out  1 each  next-stage input is invalid
- `flush_fd`  out  1  invalidate FET and DEC contents
- `mul_busy`  out  1  FSM in MUL_WAIT
- `stall_cycles`, `flush_count`  out  `CNT_W` each  performance counters

## Operation
- **Dependency.** `dep_srcN` for stage S requires all of:
  - `S.valid`, `S.reg_write_enable` and `inst_dec_in.valid`;
  - `S.dst_reg != 0`;
  - `S.dst_reg == inst_dec_in.src_reg_N`.
- Both `exe_bypass` and `mem_bypass` may assert together. The consumer resolves priority.
- **Bypass outputs** are purely combinational. They are not affected by the FSM, but they are forced to 0 while `flush_fd` is high.
- **Load-to-use** = `inst_exe_in.is_l & (exe dep_src1 | exe dep_src2)`, suppressed by freeze or flush. Effect:
  - `stall_fetch`, `stall_decode` and `bubble_exe` assert for exactly one cycle;
  - once the load advances to MEM, the condition clears by itself.
- **FSM states:** RUN, MUL_WAIT. The 4-bit down-counter is `mcnt`.
  - **RUN:** if `inst_exe_in.valid & is_m` and not frozen:
    - assert `stall_fetch`, `stall_decode`, `stall_exe` and `bubble_mem` in that same cycle (Mealy);
    - load `mcnt <= MUL_LATENCY-2`;
    - go to MUL_WAIT.
  - **MUL_WAIT:**
    - if `mcnt != 0`: same stalls and bubble, then `mcnt--`;
    - if `mcnt == 0`: no stall, return to RUN. The instruction leaves EXE at the next edge.
  - Net effect: EXE residency is `MUL_LATENCY` cycles, of which `MUL_LATENCY-1` are stalled.
- **Flush.** A qualified `branch_taken` in RUN, not frozen, causes:
  - `flush_fd = 1` for that cycle;
  - load-to-use is suppressed;
  - `flush_count++`.
- **Freeze.** A qualified `mem_busy` causes:
  - all four `stall_*` = 1 and `bubble_wb` = 1;
  - every other bubble, `flush_fd` and `load_to_use_hazard` are forced to 0;
  - the FSM state and `mcnt` hold.
- **Priority:** freeze > MUL (entry or wait) > flush > load-to-use.
- **Counters:**
  - `stall_cycles` increments on every cycle with `stall_fetch = 1`;
  - both counters wrap modulo 2^`CNT_W`.

## Timing
- **Reset** (asynchronous, any time, including mid-MUL_WAIT): state = RUN, `mcnt = 0`, both counters = 0.
  - All FSM-driven outputs are 0 while `rst` is high.
  - The combinational outputs follow the inputs.
- **Latency.** All stall, bubble and flush outputs are combinational from the inputs and state in the same cycle. Counters and state update on the rising `clk` edge.
- **Freeze during MUL_WAIT** extends the stall by exactly the number of freeze cycles.
- **Branch in EXE during freeze:** the branch is re-evaluated when the freeze ends; exactly one flush occurs.
- **Back-to-back `is_m`:** the second one enters RUN detection on the cycle after release. No idle cycle is added.
- `MUL_LATENCY == 2`: MUL_WAIT lasts one cycle with `mcnt == 0`, giving one stalled cycle total.

## Structure
- `structure_pkg`: add `hazard_state_e` (RUN, MUL_WAIT). `bypass_t` and `inst_decoded_t` are reused unchanged.
- `constants_pkg`: add `MUL_LATENCY_DEFAULT = 4`.
- One sub-module, `perf_counter` (enable, wrap, width `CNT_W`), is instantiated twice.
- Dependency compare logic stays inline.

## Test plan
- **Bypass:**
  - EXE `addi x5` and DEC `add x6, x5, x5` → `exe_bypass` = {1,1}, no stall.
  - EXE `dst = x0` → `exe_bypass` = {0,0}.
- **Load-to-use:** EXE `lw x7`, DEC `add x8, x7, x1`.
  - Cycle of detection: `load_to_use_hazard`, `stall_fetch`, `stall_decode`, `bubble_exe` = 1 for 1 cycle.
  - Next cycle, load in MEM: `mem_bypass.dep_src1` = 1.
  - `stall_cycles` = 1.
- **MUL (`MUL_LATENCY` = 4):** `mul` enters EXE at cycle t.
  - `stall_exe` = 1 at t, t+1, t+2; 0 at t+3.
  - `mul_busy` = 1 at t+1..t+3.
  - `stall_cycles` = 3.
- **Branch vs load-use:** taken `beq` in EXE while DEC holds a load-use pattern.
  - `flush_fd` = 1, `load_to_use_hazard` = 0, `flush_count` = 1.
- **Freeze:** `mem_busy` = 1 for 3 cycles during MUL_WAIT with `mcnt` = 1.
  - All stalls and `bubble_wb` = 1 for those 3 cycles.
  - The stall sequence then resumes: one more stalled cycle, then release.
- **Reset:** assert `rst` mid-MUL_WAIT.
  - Immediately: `mul_busy` = 0 and both counters = 0.
  - After release with an idle pipeline: all outputs = 0.
